instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Multicycle fetch stage that sits directly upstream of the control unit.
- Holds the PC and runs the instruction-memory request/ready handshake, including wait states.
- Latches the returned word into the instruction register (IR).
- Presents the decoded opcode/func/register/immediate fields that the control unit and datapath consume.

Parameters:
- ADDR_W, 32, width of PC and memory address
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_INC, 4, byte increment applied after each successful fetch
- MAX_WAIT, 15, maximum cycles mem_ready may stay low before fetch is aborted

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- fetch  in  1  request one instruction fetch (driven by control unit Fetch)
- pc_write  in  1  load PC from pc_next
- pc_next  in  ADDR_W  branch/jump target from datapath
- mem_req  out  1  instruction memory read request
- mem_addr  out  ADDR_W  instruction memory address
- mem_ready  in  1  memory has valid data on mem_rdata this cycle
- mem_rdata  in  32  instruction word from memory
- pc  out  ADDR_W  current program counter
- ir  out  32  instruction register
- opcode  out  6  ir[31:26]
- rs  out  5  ir[25:21]
- rt  out  5  ir[20:16]
- rd  out  5  ir[15:11]
- shamt  out  5  ir[10:6]
- func  out  6  ir[5:0]
- imm  out  16  ir[15:0]
- instr_valid  out  1  one-cycle pulse: IR updated with a new instruction
- busy  out  1  fetch in progress
- fetch_err  out  1  sticky: a fetch timed out

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. All registers update on the rising edge of clk.
- Reset values: pc=RESET_PC, ir=0, mem_req=0, mem_addr=0, instr_valid=0, busy=0, fetch_err=0, wait_cnt=0, state=IDLE.
- Reset mid-fetch: mem_req is low after that edge, and the in-flight response is discarded.
- FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - busy=0, mem_req=0.
  - pc_write=1 -> pc <= {pc_next[ADDR_W-1:2], 2'b00}. Low two bits are always forced to 0.
  - fetch=1 -> go to REQ. mem_addr <= the PC value in effect after this edge. If pc_write and fetch are both asserted, the fetch uses the aligned pc_next.
- REQ:
  - mem_req=1, busy=1. mem_addr is held stable.
  - mem_ready=1 -> ir <= mem_rdata; pc <= pc + PC_INC (mod 2^ADDR_W, wraps silently); mem_req <= 0; wait_cnt <= 0; go to DONE.
  - mem_ready=0 -> wait_cnt increments.
  - Timeout: when wait_cnt reaches MAX_WAIT with mem_ready still 0 -> mem_req <= 0, fetch_err <= 1, go to IDLE. pc and ir are unchanged. instr_valid is not pulsed.
- DONE:
  - instr_valid=1 for exactly this cycle, busy=0.
  - Next state is IDLE.
  - fetch=1 in DONE is treated as in IDLE: back-to-back fetch, one idle-equivalent cycle.
- Ignored inputs while busy (REQ): fetch and pc_write are ignored. Neither queues nor alters the in-flight address.
- Latency with zero wait states: fetch at edge t -> mem_req high during cycle t+1; mem_ready sampled at edge t+2; instr_valid and the new ir visible in cycle t+2. Each wait state adds one cycle.
- Decoded fields (opcode..imm) are purely combinational slices of ir. They are stable except on the capture edge.
- fetch_err is cleared only by rst.
- mem_rdata is only sampled when state=REQ and mem_ready=1. mem_ready outside REQ is ignored.

Test Plan:
1. Reset then fetch with mem_ready tied high, mem_rdata=32'h0109_5020 (add $t2,$t0,$t1) -> mem_addr=0, instr_valid pulse 2 cycles after fetch, opcode=0, rs=8, rt=9, rd=10, func=6'h20, pc=4.
2. Three wait states: mem_ready low 3 cycles after mem_req, then high with 32'h8C82_0010 (lw) -> mem_addr held constant throughout, opcode=6'h23, imm=16'h0010, instr_valid 5 cycles after fetch, pc advanced by 4 once.
3. pc_write=1 with pc_next=32'h0000_0103 together with fetch in IDLE -> mem_addr=32'h0000_0100; after completion pc=32'h0000_0104.
4. mem_ready held low for MAX_WAIT cycles -> mem_req drops, fetch_err=1 and stays 1, pc and ir unchanged, no instr_valid; a following fetch still operates normally.
5. pc=32'hFFFF_FFFC, fetch completes -> pc wraps to 0. Asserting fetch and pc_write during REQ -> no effect on mem_addr or pc.
6. rst asserted during the wait state of a fetch -> next cycle mem_req=0, pc=RESET_PC, ir=0, busy=0. A late mem_ready is ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: owns the PC, runs the memory request/ready
// handshake with a wait-state timeout, and exposes the IR plus its decoded fields.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_INC   = 4,
  parameter int                 MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        func,
  output logic [15:0]       imm,
  output logic              instr_valid,
  output logic              busy,
  output logic              fetch_err
);

  localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] PC_INC_W  = ADDR_W'(PC_INC);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_aligned;

  assign pc_aligned = pc_next & ALIGN_MSK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      // DONE accepts a new request exactly like IDLE, giving back-to-back fetches.
      IDLE, DONE: begin
        state_d = IDLE;
        if (pc_write) pc_d = pc_aligned;
        if (fetch) begin
          state_d = REQ;
          addr_d  = pc_write ? pc_aligned : pc_q;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_INC_W;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Request has been outstanding MAX_WAIT cycles: abandon it.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req     = (state_q == REQ);
  assign busy        = (state_q == REQ);
  assign instr_valid = (state_q == DONE);
  assign mem_addr    = addr_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign fetch_err   = err_q;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign func   = ir_q[5:0];
  assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of fetch vectors plus hand
// sequences for timeout, back-to-back fetch and reset during a wait state.
module tb_instr_fetch_unit;

  localparam int MAX_WAIT = 15;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst, fetch, pc_write, mem_ready;
  logic [31:0] pc_next, mem_rdata;
  logic        mem_req, instr_valid, busy, fetch_err;
  logic [31:0] mem_addr, pc, ir;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .pc_write(pc_write), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .ir(ir), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .func(func), .imm(imm), .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic [31:0] pc_nx;
    logic [31:0] rdata;
    int          waits;
    logic        poke;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [5:0]  exp_opcode;
    logic [4:0]  exp_rs, exp_rt, exp_rd, exp_shamt;
    logic [5:0]  exp_func;
    logic [15:0] exp_imm;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t tbl[6];
  vec_t mon_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pcw, input logic [31:0] pc_nx, input logic [31:0] rdata,
                              input int waits, input logic poke, input logic [31:0] ea,
                              input logic [31:0] epc, input logic [5:0] eop, input logic [4:0] ers,
                              input logic [4:0] ert, input logic [4:0] erd, input logic [4:0] esh,
                              input logic [5:0] efn, input logic [15:0] eimm);
    vec_t v;
    v.pcw = pcw; v.pc_nx = pc_nx; v.rdata = rdata; v.waits = waits; v.poke = poke;
    v.exp_addr = ea; v.exp_pc = epc; v.exp_opcode = eop; v.exp_rs = ers; v.exp_rt = ert;
    v.exp_rd = erd; v.exp_shamt = esh; v.exp_func = efn; v.exp_imm = eimm;
    return v;
  endfunction

  // Scoreboard: every instr_valid pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (rst === 1'b0 && instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_instr_valid: got pulse with ir=%h, expected none", ir);
      end else begin
        mon_v = sb.pop_front();
        chk("ir", ir, mon_v.rdata);
        chk("pc_after", pc, mon_v.exp_pc);
        chk("opcode", 32'(opcode), 32'(mon_v.exp_opcode));
        chk("rs", 32'(rs), 32'(mon_v.exp_rs));
        chk("rt", 32'(rt), 32'(mon_v.exp_rt));
        chk("rd", 32'(rd), 32'(mon_v.exp_rd));
        chk("shamt", 32'(shamt), 32'(mon_v.exp_shamt));
        chk("func", 32'(func), 32'(mon_v.exp_func));
        chk("imm", 32'(imm), 32'(mon_v.exp_imm));
        $display("txn addr=%h ir=%h pc=%h waits=%0d", mon_v.exp_addr, ir, pc, mon_v.waits);
      end
    end
  end

  // One fetch. pre: fetch was already raised in the previous DONE cycle.
  // chain: raise fetch in this fetch's DONE cycle for a back-to-back request.
  task automatic do_fetch(input vec_t v, input bit pre, input bit chain);
    if (!pre) begin
      fetch = 1'b1; pc_write = v.pcw; pc_next = v.pc_nx;
    end
    sb.push_back(v);
    @(posedge clk); #1;
    fetch = 1'b0; pc_write = 1'b0; pc_next = '0;
    chk("req_mem_req", 32'(mem_req), 32'd1);
    chk("req_busy", 32'(busy), 32'd1);
    chk("req_instr_valid", 32'(instr_valid), 32'd0);
    chk("req_mem_addr", mem_addr, v.exp_addr);
    for (int w = 0; w < v.waits; w++) begin
      mem_ready = 1'b0;
      mem_rdata = JUNK;
      if (v.poke) begin
        fetch = 1'b1; pc_write = 1'b1; pc_next = 32'hDEAD_BEE0;
      end
      @(posedge clk); #1;
      fetch = 1'b0; pc_write = 1'b0; pc_next = '0;
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_mem_addr", mem_addr, v.exp_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = v.rdata;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = JUNK;
    chk("done_instr_valid", 32'(instr_valid), 32'd1);
    chk("done_mem_req", 32'(mem_req), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    if (chain) begin
      fetch = 1'b1;
    end else begin
      @(posedge clk); #1;
      chk("post_instr_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(0, 32'h0,         32'h0109_5020, 0,  0, 32'h0000_0000, 32'h0000_0004,
                6'h00, 5'd8,  5'd9,  5'd10, 5'd0,  6'h20, 16'h5020);
    tbl[1] = mk(0, 32'h0,         32'h8C82_0010, 3,  0, 32'h0000_0004, 32'h0000_0008,
                6'h23, 5'd4,  5'd2,  5'd0,  5'd0,  6'h10, 16'h0010);
    tbl[2] = mk(1, 32'h0000_0103, 32'h2008_FFFF, 0,  0, 32'h0000_0100, 32'h0000_0104,
                6'h08, 5'd0,  5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF);
    tbl[3] = mk(0, 32'h0,         32'hFFFF_FFFF, MAX_WAIT - 1, 0, 32'h0000_0104, 32'h0000_0108,
                6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF);
    tbl[4] = mk(1, 32'hFFFF_FFFF, 32'h0000_0000, 2,  1, 32'hFFFF_FFFC, 32'h0000_0000,
                6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000);
    tbl[5] = mk(0, 32'h0,         32'h3C01_1234, 1,  0, 32'h0000_0000, 32'h0000_0004,
                6'h0F, 5'd0,  5'd1,  5'd2,  5'd8,  6'h34, 16'h1234);

    rst = 1'b1; fetch = 1'b0; pc_write = 1'b0; pc_next = '0;
    mem_ready = 1'b0; mem_rdata = JUNK;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) do_fetch(tbl[i], 1'b0, 1'b0);

    // Back-to-back: second fetch raised during the first one's DONE cycle.
    do_fetch(mk(0, 32'h0, 32'h0000_0020, 0, 0, 32'h0000_0004, 32'h0000_0008,
                6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h20, 16'h0020), 1'b0, 1'b1);
    do_fetch(mk(0, 32'h0, 32'hAC82_0004, 1, 0, 32'h0000_0008, 32'h0000_000C,
                6'h2B, 5'd4, 5'd2, 5'd0, 5'd0, 6'h04, 16'h0004), 1'b1, 1'b0);

    // Timeout: mem_ready never arrives.
    fetch = 1'b1;
    @(posedge clk); #1;
    fetch = 1'b0;
    chk("to_mem_req_first", 32'(mem_req), 32'd1);
    for (int i = 1; i < MAX_WAIT; i++) begin
      @(posedge clk); #1;
      chk("to_mem_req_hold", 32'(mem_req), 32'd1);
      chk("to_instr_valid", 32'(instr_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("to_mem_req_drop", 32'(mem_req), 32'd0);
    chk("to_fetch_err", 32'(fetch_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_pc", pc, 32'h0000_000C);
    chk("to_ir", ir, 32'hAC82_0004);
    chk("to_instr_valid_after", 32'(instr_valid), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = JUNK;
    chk("stray_ready_ir", ir, 32'hAC82_0004);
    chk("stray_ready_pc", pc, 32'h0000_000C);
    do_fetch(mk(0, 32'h0, 32'h0109_5020, 0, 0, 32'h0000_000C, 32'h0000_0010,
                6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h5020), 1'b0, 1'b0);
    chk("err_sticky", 32'(fetch_err), 32'd1);

    // Reset while waiting on memory; a late mem_ready must be ignored.
    fetch = 1'b1;
    @(posedge clk); #1;
    fetch = 1'b0;
    chk("rw_mem_addr", mem_addr, 32'h0000_0010);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_pc", pc, 32'h0);
    chk("rw_ir", ir, 32'h0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_fetch_err", 32'(fetch_err), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rw_late_ready_valid", 32'(instr_valid), 32'd0);
      chk("rw_late_ready_ir", ir, 32'h0);
    end
    mem_ready = 1'b0; mem_rdata = JUNK;
    do_fetch(tbl[5], 1'b0, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
